// File: rtl/uart_boot_loader_pkg.sv
// Shared definitions for the UART boot loader: FSM state encoding, the default
// frame start marker and the byte order of a frame.
package uart_boot_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN_HI  = 3'd1,
    ST_LEN_LO  = 3'd2,
    ST_DATA_HI = 3'd3,
    ST_DATA_LO = 3'd4,
    ST_CHECK   = 3'd5,
    ST_DONE    = 3'd6,
    ST_ERROR   = 3'd7
  } state_e;

  localparam logic [7:0] START_BYTE_DEFAULT = 8'hA5;

  // Byte position of each frame field; CHK follows the 2*LEN data bytes.
  localparam int unsigned FIELD_START  = 0;
  localparam int unsigned FIELD_LEN_HI = 1;
  localparam int unsigned FIELD_LEN_LO = 2;
  localparam int unsigned FIELD_DATA   = 3;

  function automatic logic in_frame(input state_e s);
    return s inside {ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO, ST_CHECK};
  endfunction

endpackage

// File: rtl/uart_boot_loader_idle_timer.sv
// Inter-byte idle timer: a down-counter reloaded on every clear, flagging
// expiry when it reaches zero while enabled. TIMEOUT_CYCLES = 0 disables it.
module uart_boot_loader_idle_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  if (TIMEOUT_CYCLES == 0) begin : g_off
    assign o_expired = 1'b0;
  end else begin : g_on
    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    // Reload with N-1 so expiry lands exactly N edges after the clearing edge.
    always_comb begin
      cnt_d = cnt_q;
      if (i_clear)
        cnt_d = CW'(TIMEOUT_CYCLES - 1);
      else if (i_enable && (cnt_q != '0))
        cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge i_clk) begin
      if (i_reset) cnt_q <= '0;
      else         cnt_q <= cnt_d;
    end

    assign o_expired = i_enable && (cnt_q == '0);
  end

endmodule

// File: rtl/uart_boot_loader.sv
// Frame receiver that writes a UART-delivered program image into program RAM
// and holds the CPU in reset until a checksum-verified image is loaded.
//
// state   | meaning
// IDLE    | waiting for the start byte, other bytes ignored
// LEN_HI  | expecting length high byte
// LEN_LO  | expecting length low byte, range-checked on arrival
// DATA_HI | expecting high byte of the next word
// DATA_LO | expecting low byte; the word is written on arrival
// CHECK   | expecting the checksum byte
// DONE    | image verified, CPU released, deaf until reset
// ERROR   | frame aborted, waiting for a new start byte
module uart_boot_loader
  import uart_boot_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter logic [15:0] LOAD_BASE      = 16'h0000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0]  START_BYTE     = START_BYTE_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_ram_load,
  output logic [15:0] o_ram_addr,
  output logic [15:0] o_ram_data,
  output logic        o_cpu_reset,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error
);

  localparam logic [16:0] MAX_LEN = 17'(1) << ADDR_WIDTH;

  state_e      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] word_cnt_q, word_cnt_d;
  logic [7:0]  sum_q, sum_d;
  logic [7:0]  hi_q, hi_d;
  logic        load_q, load_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic        cpu_reset_q, cpu_reset_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        timeout;
  logic [15:0] len_new;
  logic [15:0] word_cnt_inc;

  uart_boot_loader_idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_clear  (i_rx_valid),
    .i_enable (in_frame(state_q)),
    .o_expired(timeout)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      word_cnt_q  <= '0;
      sum_q       <= '0;
      hi_q        <= '0;
      load_q      <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      word_cnt_q  <= word_cnt_d;
      sum_q       <= sum_d;
      hi_q        <= hi_d;
      load_q      <= load_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      cpu_reset_q <= cpu_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign len_new      = {len_q[15:8], i_rx_data};
  assign word_cnt_inc = word_cnt_q + 16'd1;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    sum_d      = sum_q;
    hi_d       = hi_q;
    load_d     = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    // A byte arriving in the expiry cycle takes priority over the timeout.
    if (i_rx_valid) begin
      case (state_q)
        ST_IDLE, ST_ERROR: begin
          if (i_rx_data == START_BYTE) begin
            state_d    = ST_LEN_HI;
            sum_d      = '0;
            word_cnt_d = '0;
          end
        end
        ST_LEN_HI: begin
          len_d[15:8] = i_rx_data;
          sum_d       = sum_q + i_rx_data;
          state_d     = ST_LEN_LO;
        end
        ST_LEN_LO: begin
          len_d = len_new;
          sum_d = sum_q + i_rx_data;
          if ({1'b0, len_new} > MAX_LEN) state_d = ST_ERROR;
          else if (len_new == '0)        state_d = ST_CHECK;
          else                           state_d = ST_DATA_HI;
        end
        ST_DATA_HI: begin
          hi_d    = i_rx_data;
          sum_d   = sum_q + i_rx_data;
          state_d = ST_DATA_LO;
        end
        ST_DATA_LO: begin
          load_d     = 1'b1;
          addr_d     = LOAD_BASE + word_cnt_q;
          data_d     = {hi_q, i_rx_data};
          word_cnt_d = word_cnt_inc;
          sum_d      = sum_q + i_rx_data;
          state_d    = (word_cnt_inc == len_q) ? ST_CHECK : ST_DATA_HI;
        end
        ST_CHECK: state_d = (i_rx_data == sum_q) ? ST_DONE : ST_ERROR;
        default:  state_d = state_q;
      endcase
    end else if (timeout) begin
      state_d = ST_ERROR;
    end
  end

  always_comb begin
    cpu_reset_d = (state_d != ST_DONE);
    busy_d      = in_frame(state_d);
    done_d      = (state_d == ST_DONE);
    error_d     = (state_d == ST_ERROR);
  end

  assign o_ram_load  = load_q;
  assign o_ram_addr  = addr_q;
  assign o_ram_data  = data_q;
  assign o_cpu_reset = cpu_reset_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_error     = error_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader: a cycle-by-cycle vector table for a
// back-to-back two-word frame, then hand-written multi-cycle corner cases.
module tb_uart_boot_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  din = 8'h00;
  logic        vld = 1'b0;

  logic        ld0, cpu0, busy0, done0, err0;
  logic [15:0] addr0, data0;
  logic        ld1, cpu1, busy1, done1, err1;
  logic [15:0] addr1, data1;

  int checks = 0;
  int errors = 0;

  logic [15:0] wa[$];
  logic [15:0] wd[$];

  always #5 clk = ~clk;

  uart_boot_loader #(
    .ADDR_WIDTH(8), .LOAD_BASE(16'h0000), .TIMEOUT_CYCLES(20), .START_BYTE(8'hA5)
  ) dut0 (
    .i_clk(clk), .i_reset(rst), .i_rx_data(din), .i_rx_valid(vld),
    .o_ram_load(ld0), .o_ram_addr(addr0), .o_ram_data(data0),
    .o_cpu_reset(cpu0), .o_busy(busy0), .o_done(done0), .o_error(err0)
  );

  uart_boot_loader #(
    .ADDR_WIDTH(8), .LOAD_BASE(16'hFFFF), .TIMEOUT_CYCLES(20), .START_BYTE(8'hA5)
  ) dut1 (
    .i_clk(clk), .i_reset(rst), .i_rx_data(din), .i_rx_valid(vld),
    .o_ram_load(ld1), .o_ram_addr(addr1), .o_ram_data(data1),
    .o_cpu_reset(cpu1), .o_busy(busy1), .o_done(done1), .o_error(err1)
  );

  // RAM-side view of dut0: the word is captured while the pulse is high.
  always @(negedge clk) begin
    if (ld0) begin
      wa.push_back(addr0);
      wd.push_back(data0);
    end
  end

  typedef struct {
    logic        rst;
    logic        vld;
    logic [7:0]  din;
    logic        load;
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] addr1;
    logic [3:0]  st;     // {cpu_reset, busy, done, error}
  } vec_t;

  vec_t vt[12];

  function automatic vec_t mk(input logic r, input logic v, input logic [7:0] d,
                              input logic l, input logic [15:0] a, input logic [15:0] dt,
                              input logic [15:0] a1, input logic [3:0] st);
    vec_t x;
    x.rst = r; x.vld = v; x.din = d; x.load = l;
    x.addr = a; x.data = dt; x.addr1 = a1; x.st = st;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1; vld = 1'b0;
    step();
    rst = 1'b0;
    wa.delete();
    wd.delete();
  endtask

  task automatic strobe(input logic [7:0] b);
    vld = 1'b1; din = b;
    step();
    vld = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] b[$], input int gap);
    foreach (b[i]) begin
      strobe(b[i]);
      idle(gap - 1);
    end
  endtask

  task automatic chk_status(input string nm, input logic [3:0] exp);
    chk(nm, {28'd0, cpu0, busy0, done0, err0}, {28'd0, exp});
  endtask

  initial begin
    logic [15:0] exp_d[4];
    exp_d[0] = 16'h1122; exp_d[1] = 16'h3344; exp_d[2] = 16'h5566; exp_d[3] = 16'h7788;

    // Back-to-back frame A5 00 02 12 34 AB CD, checksum 00+02+12+34+AB+CD = C0.
    vt[0]  = mk(1, 0, 8'h00, 0, 16'h0000, 16'h0000, 16'h0000, 4'b1000);
    vt[1]  = mk(0, 1, 8'hA5, 0, 16'h0000, 16'h0000, 16'h0000, 4'b1100);
    vt[2]  = mk(0, 1, 8'h00, 0, 16'h0000, 16'h0000, 16'h0000, 4'b1100);
    vt[3]  = mk(0, 1, 8'h02, 0, 16'h0000, 16'h0000, 16'h0000, 4'b1100);
    vt[4]  = mk(0, 1, 8'h12, 0, 16'h0000, 16'h0000, 16'h0000, 4'b1100);
    vt[5]  = mk(0, 1, 8'h34, 1, 16'h0000, 16'h1234, 16'hFFFF, 4'b1100);
    vt[6]  = mk(0, 1, 8'hAB, 0, 16'h0000, 16'h1234, 16'hFFFF, 4'b1100);
    vt[7]  = mk(0, 1, 8'hCD, 1, 16'h0001, 16'hABCD, 16'h0000, 4'b1100);
    vt[8]  = mk(0, 1, 8'hC0, 0, 16'h0001, 16'hABCD, 16'h0000, 4'b0010);
    vt[9]  = mk(0, 1, 8'hA5, 0, 16'h0001, 16'hABCD, 16'h0000, 4'b0010);
    vt[10] = mk(0, 0, 8'h00, 0, 16'h0001, 16'hABCD, 16'h0000, 4'b0010);
    vt[11] = mk(1, 0, 8'h00, 0, 16'h0000, 16'h0000, 16'h0000, 4'b1000);

    for (int i = 0; i < 12; i++) begin
      rst = vt[i].rst; vld = vt[i].vld; din = vt[i].din;
      step();
      chk($sformatf("vec%0d.load", i),  {31'd0, ld0}, {31'd0, vt[i].load});
      chk($sformatf("vec%0d.addr", i),  {16'd0, addr0}, {16'd0, vt[i].addr});
      chk($sformatf("vec%0d.data", i),  {16'd0, data0}, {16'd0, vt[i].data});
      chk_status($sformatf("vec%0d.status", i), vt[i].st);
      chk($sformatf("vec%0d.load_b", i), {31'd0, ld1}, {31'd0, vt[i].load});
      chk($sformatf("vec%0d.addr_b", i), {16'd0, addr1}, {16'd0, vt[i].addr1});
      chk($sformatf("vec%0d.data_b", i), {16'd0, data1}, {16'd0, vt[i].data});
      chk($sformatf("vec%0d.status_b", i), {28'd0, cpu1, busy1, done1, err1}, {28'd0, vt[i].st});
    end
    rst = 1'b0; vld = 1'b0;

    // Bad checksum, spaced 3 cycles, then recovery with a good frame.
    do_reset();
    send_bytes('{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD}, 3);
    strobe(8'hC1);
    chk_status("badchk.status", 4'b1001);
    chk("badchk.writes", wa.size(), 2);
    idle(2);
    strobe(8'hA5);
    chk_status("restart.status", 4'b1100);
    idle(2);
    send_bytes('{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD}, 3);
    strobe(8'hC0);
    chk_status("recover.status", 4'b0010);
    chk("recover.writes", wa.size(), 4);
    chk("recover.addr0", {16'd0, wa[2]}, 32'h0000);
    chk("recover.data1", {16'd0, wd[3]}, 32'hABCD);

    // Zero-length frame.
    do_reset();
    send_bytes('{8'hA5, 8'h00, 8'h00}, 3);
    strobe(8'h00);
    chk_status("len0.status", 4'b0010);
    chk("len0.writes", wa.size(), 0);

    // Length 257 exceeds 2^8 words.
    do_reset();
    send_bytes('{8'hA5, 8'h01}, 3);
    strobe(8'h01);
    chk_status("toolong.status", 4'b1001);

    // Leading garbage, then one word BEEF (checksum 01+BE+EF = AE).
    do_reset();
    send_bytes('{8'h00, 8'hFF}, 3);
    chk_status("garbage.status", 4'b1000);
    send_bytes('{8'hA5, 8'h00, 8'h01, 8'hBE, 8'hEF}, 3);
    strobe(8'hAE);
    chk_status("beef.status", 4'b0010);
    chk("beef.writes", wa.size(), 1);
    if (wa.size() == 1) begin
      chk("beef.addr", {16'd0, wa[0]}, 32'h0000);
      chk("beef.data", {16'd0, wd[0]}, 32'hBEEF);
    end

    // Timeout after BE: error exactly on the 20th edge after the strobe.
    do_reset();
    send_bytes('{8'hA5, 8'h00, 8'h01}, 3);
    strobe(8'hBE);
    idle(19);
    chk_status("timeout.edge19", 4'b1100);
    step();
    chk_status("timeout.edge20", 4'b1001);
    idle(3);
    chk_status("timeout.after", 4'b1001);

    // A byte arriving on the expiry edge wins over the timeout.
    do_reset();
    send_bytes('{8'hA5, 8'h00, 8'h01}, 3);
    strobe(8'hBE);
    idle(19);
    strobe(8'hEF);
    chk_status("bytewins.status", 4'b1100);
    chk("bytewins.load", {31'd0, ld0}, 32'd1);
    chk("bytewins.data", {16'd0, data0}, 32'hBEEF);
    strobe(8'hAE);
    chk_status("bytewins.done", 4'b0010);

    // Back-to-back 4-word frame, checksum 68.
    do_reset();
    send_bytes('{8'hA5, 8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44,
                 8'h55, 8'h66, 8'h77, 8'h88}, 1);
    strobe(8'h68);
    chk_status("b2b4.status", 4'b0010);
    chk("b2b4.writes", wa.size(), 4);
    if (wa.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("b2b4.addr%0d", i), {16'd0, wa[i]}, i);
        chk($sformatf("b2b4.data%0d", i), {16'd0, wd[i]}, {16'd0, exp_d[i]});
      end
    end

    // Reset arrives with the low byte of word 2: that write is squashed.
    do_reset();
    send_bytes('{8'hA5, 8'h00, 8'h04, 8'h11, 8'h22, 8'h33}, 1);
    rst = 1'b1; vld = 1'b1; din = 8'h44;
    step();
    rst = 1'b0; vld = 1'b0;
    chk("midrst.load", {31'd0, ld0}, 32'd0);
    chk("midrst.addr", {16'd0, addr0}, 32'h0000);
    chk("midrst.data", {16'd0, data0}, 32'h0000);
    chk_status("midrst.status", 4'b1000);
    send_bytes('{8'h55, 8'h66, 8'h77, 8'h88, 8'h68}, 1);
    idle(2);
    chk("midrst.writes", wa.size(), 1);
    chk_status("midrst.final", 4'b1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
